led_mode_sequencer: RTL and testbench
=====================================

# led_mode_sequencer

Top-level scheduler for the LED pattern drivers. It owns the shared 8-bit LED bank and grants it to exactly one mode driver at a time. Every other driver is held in reset, so each mode restarts from phase 0 when it is selected. The sequencer advances through modes on a debounced push-button press and, optionally, on a dwell timer. A short blanking gap separates consecutive modes.

## Interface
Parameters:
- `NUM_MODES`, 4: number of attached mode drivers; must be ≥ 2.
- `BLANK_CYCLES`, 16: length of the dark gap between modes, in clocks; must be ≥ 1.
- `DWELL_CYCLES`, 24000: RUN length per mode when auto-cycle is compiled in.
- `DEBOUNCE_CYCLES`, 1000: stable-level time required on the key, in clocks.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  1  raw button input, active low, asynchronous to `clk`.
- `pause`  in  1  level input; freezes the dwell timer.
- `mode_led`  in  NUM_MODES*8  concatenated driver outputs; mode k occupies bits [8k+7:8k].
- `mode_rst_n`  out  NUM_MODES  per-driver reset, active low, registered.
- `led_out`  out  8  registered LED bank output.
- `cur_mode`  out  $clog2(NUM_MODES)  index of the selected mode.
- `busy`  out  1  high while in BLANK.

## Operation
- States:
  - BLANK: `led_out`=0, `mode_rst_n`=all 0.
  - RUN: `mode_rst_n`=one-hot(`cur_mode`); `led_out` is driven from the `cur_mode` slice of `mode_led`.
- Reset values: state=BLANK, `cur_mode`=0, `busy`=1, `led_out`=0, `mode_rst_n`=0, all counters 0.
- BLANK to RUN: taken when the blank counter reaches BLANK_CYCLES-1.
- Advance event: a debounced press pulse, or dwell expiry (see Configuration).
- Advance action:
  - `cur_mode` wraps: NUM_MODES-1 goes to 0; otherwise `cur_mode`+1.
  - State goes to BLANK; blank and dwell counters clear.
- Key press and dwell expiry in the same cycle: a single advance.
- Press pulse during BLANK: dropped, not queued.
- `pause`=1: the dwell counter holds its value. Key presses still advance. `pause` has no effect in BLANK.
- Debounce:
  - `key_n` passes through a 2-FF synchronizer.
  - A press is accepted only after the synchronized level stays low for DEBOUNCE_CYCLES consecutive clocks. This emits one 1-cycle press pulse.
  - Re-arm requires the level to stay high for DEBOUNCE_CYCLES consecutive clocks.
  - Any level change restarts the debounce count.
- Counter widths are $clog2(max+1) of the respective parameter. No counter overflows; each clears on its terminal compare.

## Timing
- BLANK lasts exactly BLANK_CYCLES clocks, with `busy`=1 throughout.
- First RUN cycle: `busy`=0 and `mode_rst_n` bit goes high in the same cycle. `led_out` is still 0.
- From then on, `led_out`(t) = `mode_led` slice(t-1): one-cycle latency.
- RUN lasts exactly DWELL_CYCLES clocks, absent `pause` and key presses.
- `cur_mode` updates in the first BLANK cycle, together with `busy` rising and `led_out` forced to 0.
- Press pulse latency: 3 + DEBOUNCE_CYCLES clocks (±1) after `key_n` settles low. The advance is visible the following cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). The sequence restarts at mode 0 with a full BLANK.

## Configuration
- Macro: `LED_SEQ_AUTO_CYCLE_EN`.
- Defined: dwell counter is present. Reaching DWELL_CYCLES-1 in RUN with `pause`=0 generates an advance.
- Undefined:
  - The dwell counter is not synthesized, so only key presses advance.
  - `pause` is accepted but ignored.
  - RUN lasts indefinitely.

## Structure
- Shared package `led_pkg`:
  - LED bank width constant `LED_W`=8.
  - Sequencer state enum (BLANK, RUN).
  - Default timing constants (debounce, blank, dwell).
- Sub-module `key_debounce`:
  - Contains the synchronizer, debounce counter and press-pulse output.
  - Parameterized by DEBOUNCE_CYCLES.
  - Reused by any future button inputs.
- The mode mux and the one-hot reset decode stay inline in `led_mode_sequencer`.

## Test plan
Bench parameters: NUM_MODES=4, BLANK_CYCLES=4, DWELL_CYCLES=20, DEBOUNCE_CYCLES=8, auto-cycle defined unless noted.
- Reset release:
  - `busy`=1, `led_out`=0, `mode_rst_n`=4'b0000 for 4 clocks.
  - Then `busy`=0 and `mode_rst_n`=4'b0001.
  - `led_out` equals `mode_led`[7:0] delayed by one clock.
- Auto cycle, `pause`=0, no key: `cur_mode` steps 0→1→2→3→0 every 24 clocks.
- Macro undefined: `cur_mode` stays 0 for 200 clocks.
- Bouncy key: `key_n` toggles every 3 clocks for 30 clocks, then holds low for 20 clocks.
  - Exactly one advance (0→1).
  - No second advance until the key is held high ≥ 8 clocks and pressed again.
- `pause`=1 in RUN of mode 2 for 100 clocks: `cur_mode` stays 2.
- Key press during that pause: `cur_mode`=3, followed by a 4-clock BLANK.
- Simultaneous events:
  - Press pulse coinciding with dwell expiry: a single advance (1→2, not 3).
  - Press pulse during BLANK: ignored.
- `rst_n` pulsed low mid-BLANK while `cur_mode`=3: immediately `cur_mode`=0, `busy`=1, `mode_rst_n`=0, `led_out`=0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern subsystem: bank width, sequencer
// state encoding and default timing constants.
package led_pkg;

    localparam int unsigned LED_W               = 8;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000;
    localparam int unsigned BLANK_CYCLES_DEF    = 16;
    localparam int unsigned DWELL_CYCLES_DEF    = 24000;

    typedef enum logic [0:0] {
        StBlank = 1'b0,
        StRun   = 1'b1
    } seq_state_e;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level debounce and a
// single-cycle press pulse on each accepted high-to-low transition.
module key_debounce
    import led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;  // debounced level, 1 = released
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Count consecutive samples that disagree with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Grants the shared LED bank to one mode driver at a time, with a dark gap
// between modes. Auto-cycling on a dwell timer is built with LED_SEQ_AUTO_CYCLE_EN.
module led_mode_sequencer
    import led_pkg::*;
#(
    parameter int unsigned  NUM_MODES       = 4,
    parameter int unsigned  BLANK_CYCLES    = BLANK_CYCLES_DEF,
    parameter int unsigned  DWELL_CYCLES    = DWELL_CYCLES_DEF,
    parameter int unsigned  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    localparam int unsigned MW              = $clog2(NUM_MODES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       key_n,
    input  logic                       pause,
    input  logic [NUM_MODES*LED_W-1:0] mode_led,
    output logic [NUM_MODES-1:0]       mode_rst_n,
    output logic [LED_W-1:0]           led_out,
    output logic [MW-1:0]              cur_mode,
    output logic                       busy
);

    localparam int unsigned   BW         = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [MW-1:0] MODE_LAST  = MW'(NUM_MODES - 1);

    seq_state_e             state_q, state_d;
    logic [BW-1:0]          blank_cnt_q, blank_cnt_d;
    logic [MW-1:0]          cur_mode_q, cur_mode_d;
    logic [LED_W-1:0]       led_out_q, led_out_d;
    logic [NUM_MODES-1:0]   mode_rst_n_q, mode_rst_n_d;
    logic [LED_W-1:0]       mode_slice [NUM_MODES];
    logic                   press;
    logic                   dwell_done;
    logic                   advance;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n_i(key_n),
        .press_o(press)
    );

    // Presses arriving during BLANK are dropped rather than queued.
    assign advance = (state_q == StRun) && (press || dwell_done);

`ifdef LED_SEQ_AUTO_CYCLE_EN
    localparam int unsigned   DW         = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;

    assign dwell_done = (state_q == StRun) && !pause && (dwell_cnt_q == DWELL_LAST);

    always_comb begin
        dwell_cnt_d = dwell_cnt_q;
        if ((state_q != StRun) || advance) begin
            dwell_cnt_d = '0;
        end else if (!pause) begin
            dwell_cnt_d = dwell_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt_q <= '0;
        end else begin
            dwell_cnt_q <= dwell_cnt_d;
        end
    end
`else
    logic unused_dwell_cfg;

    assign dwell_done       = 1'b0;
    assign unused_dwell_cfg = pause | (DWELL_CYCLES == 0);
`endif

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        cur_mode_d  = cur_mode_q;
        case (state_q)
            StBlank: begin
                if (blank_cnt_q == BLANK_LAST) begin
                    state_d     = StRun;
                    blank_cnt_d = '0;
                end else begin
                    blank_cnt_d = blank_cnt_q + BW'(1);
                end
            end
            StRun: begin
                if (advance) begin
                    state_d     = StBlank;
                    blank_cnt_d = '0;
                    cur_mode_d  = (cur_mode_q == MODE_LAST) ? '0 : cur_mode_q + MW'(1);
                end
            end
            default: state_d = StBlank;
        endcase
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_MODES; k++) begin
            mode_slice[k] = mode_led[k*LED_W +: LED_W];
        end
    end

    // Outputs follow the next state so the driver leaves reset in the first RUN
    // cycle; the bank stays dark until that driver has had one clock to start.
    always_comb begin
        led_out_d    = '0;
        mode_rst_n_d = '0;
        if (state_d == StRun) begin
            mode_rst_n_d = NUM_MODES'(1) << cur_mode_d;
            if (state_q == StRun) begin
                led_out_d = mode_slice[cur_mode_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBlank;
            blank_cnt_q  <= '0;
            cur_mode_q   <= '0;
            led_out_q    <= '0;
            mode_rst_n_q <= '0;
        end else begin
            state_q      <= state_d;
            blank_cnt_q  <= blank_cnt_d;
            cur_mode_q   <= cur_mode_d;
            led_out_q    <= led_out_d;
            mode_rst_n_q <= mode_rst_n_d;
        end
    end

    assign led_out    = led_out_q;
    assign mode_rst_n = mode_rst_n_q;
    assign cur_mode   = cur_mode_q;
    assign busy       = (state_q == StBlank);

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Randomized bench for led_mode_sequencer against a cycle-level behavioural
// model of the mode schedule and button debounce.
module tb_led_mode_sequencer;

    localparam int N   = 4;
    localparam int B   = 4;
    localparam int DW  = 20;
    localparam int DEB = 8;
`ifdef LED_SEQ_AUTO_CYCLE_EN
    localparam bit AUTO      = 1'b1;
    localparam int COINC_D   = DW - 3 - DEB;
    localparam int INBLANK_D = DW - 5 - DEB;
`else
    localparam bit AUTO      = 1'b0;
    localparam int COINC_D   = 0;
    localparam int INBLANK_D = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_n;
    logic          pause;
    logic [N*8-1:0] mode_led;
    logic [N-1:0]  mode_rst_n;
    logic [7:0]    led_out;
    logic [1:0]    cur_mode;
    logic          busy;

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    bit         kq[$];
    bit         seen[$];
    bit         lvl;
    bit         press_prev;
    bit         run;
    int         m;
    int         tcnt;
    int         dwell;
    logic [7:0] led_exp;

    bit         found;
    int         mb;
    logic [7:0] prev;

    always #5 clk = ~clk;

    led_mode_sequencer #(
        .NUM_MODES      (N),
        .BLANK_CYCLES   (B),
        .DWELL_CYCLES   (DW),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .pause     (pause),
        .mode_led  (mode_led),
        .mode_rst_n(mode_rst_n),
        .led_out   (led_out),
        .cur_mode  (cur_mode),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        kq.delete();
        kq.push_back(1'b1);
        kq.push_back(1'b1);
        seen.delete();
        lvl        = 1'b1;
        press_prev = 1'b0;
        run        = 1'b0;
        m          = 0;
        tcnt       = 0;
        dwell      = 0;
        led_exp    = '0;
    endtask

    // One clock of the schedule, using inputs as they stood at the edge.
    task automatic model_step();
        bit adv;
        bit s;
        bit all_diff;
        adv = run && (press_prev || (AUTO && !pause && dwell == DW - 1));
        if (!run) begin
            led_exp = '0;
            if (tcnt == B - 1) begin
                run  = 1'b1;
                tcnt = 0;
            end else begin
                tcnt++;
            end
        end else if (adv) begin
            m       = (m + 1) % N;
            run     = 1'b0;
            tcnt    = 0;
            dwell   = 0;
            led_exp = '0;
        end else begin
            led_exp = mode_led[m*8 +: 8];
            if (AUTO && !pause) dwell++;
        end
        // Debounce sees the key two clocks late; DEB agreeing samples flip it.
        kq.push_back(key_n);
        s = kq.pop_front();
        seen.push_back(s);
        if (seen.size() > DEB) void'(seen.pop_front());
        press_prev = 1'b0;
        all_diff   = (seen.size() == DEB);
        foreach (seen[i]) if (seen[i] == lvl) all_diff = 1'b0;
        if (all_diff) begin
            lvl        = ~lvl;
            press_prev = ~lvl;
            seen.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_val("busy", 32'(busy), 32'(!run));
        check_val("cur_mode", 32'(cur_mode), m);
        check_val("mode_rst_n", 32'(mode_rst_n), run ? (32'd1 << m) : 32'd0);
        check_val("led_out", 32'(led_out), 32'(led_exp));
        mode_led = $urandom();
    endtask

    task automatic press_release();
        key_n = 1'b0;
        repeat (DEB + 4) tick();
        key_n = 1'b1;
        repeat (DEB + 4) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_mode"}, 32'(cur_mode), 32'd0);
        check_val({tag, "_rstn"}, 32'(mode_rst_n), 32'd0);
        check_val({tag, "_led"}, 32'(led_out), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        key_n    = 1'b1;
        pause    = 1'b0;
        mode_led = $urandom();
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // Reset release: B dark cycles, then mode 0 out of reset.
        rst_n = 1'b1;
        check_val("rel_busy", 32'(busy), 32'd1);
        for (int i = 0; i < B - 1; i++) begin
            tick();
            check_val("rel_busy", 32'(busy), 32'd1);
            check_val("rel_rstn", 32'(mode_rst_n), 32'd0);
        end
        tick();
        check_val("rel_busy_lo", 32'(busy), 32'd0);
        check_val("rel_rstn_on", 32'(mode_rst_n), 32'd1);
        check_val("rel_led_first", 32'(led_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            prev = mode_led[7:0];
            tick();
            check_val("led_latency", 32'(led_out), 32'(prev));
        end

        repeat (100) tick();

        // Bouncy key, then a clean hold and a second press.
        for (int i = 0; i < 30; i++) begin
            key_n = ((i / 3) % 2) != 0;
            tick();
        end
        key_n = 1'b0;
        repeat (20) tick();
        key_n = 1'b1;
        repeat (20) tick();
        press_release();

        // Press pulse landing on the dwell-expiry clock.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (run && dwell == COINC_D) found = 1'b1;
            else tick();
        end
        check_val("wait_coinc", 32'(found), 32'd1);
        mb    = m;
        key_n = 1'b0;
        repeat (DEB + 4) tick();
        check_val("coinc_single_adv", 32'(cur_mode), (mb + 1) % N);
        key_n = 1'b1;
        repeat (DEB + 4) tick();

        // Press pulse landing two clocks into BLANK.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (run && dwell == INBLANK_D) found = 1'b1;
            else tick();
        end
        check_val("wait_inblank", 32'(found), 32'd1);
        mb    = m;
        key_n = 1'b0;
        repeat (DEB + 6) tick();
        check_val("blank_press_drop", 32'(cur_mode), (mb + 1) % N);
        key_n = 1'b1;
        repeat (DEB + 4) tick();

        // Pause in RUN of mode 2, then a key press while paused.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (run && m == 2) found = 1'b1;
            else if (!AUTO) press_release();
            else tick();
        end
        check_val("wait_mode2", 32'(found), 32'd1);
        pause = 1'b1;
        repeat (100) tick();
        check_val("pause_hold", 32'(cur_mode), 32'd2);
        key_n = 1'b0;
        repeat (DEB + 4) tick();
        check_val("pause_key_adv", 32'(cur_mode), 32'd3);
        check_val("pause_key_blank", 32'(busy), 32'd1);
        key_n = 1'b1;
        repeat (DEB + 4) tick();
        pause = 1'b0;

        // Random key activity and pause.
        for (int i = 0; i < 120; i++) begin
            key_n = 1'($urandom_range(0, 1));
            pause = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 20)) tick();
        end
        key_n = 1'b1;
        pause = 1'b0;
        repeat (DEB + 4) tick();

        // Asynchronous reset in the middle of BLANK.
        key_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (!run) found = 1'b1;
            else tick();
        end
        check_val("wait_blank", 32'(found), 32'd1);
        key_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
